btb_lru_policy_ctrl: RTL and testbench
======================================

// Module: btb_lru_policy_ctrl
// PURPOSE
// - Pseudo-LRU policy engine for the BTB: reader/updater client of the BTB LRU storage array.
// - Drives the array read index and samples its combinational read data.
// - Computes tree-PLRU victim/MRU bits and drives the array write port.
// - Serves BTB hit (touch) events and BTB fill (victim request) handshakes from the fetch stage.
// PARAMETERS
// - WAYS   4  associativity; 2 or 4 legal
// - IDX_W  3  set index width (matches lc3b_index, 8 sets)
// - LRU_W  WAYS-1  PLRU bits per set (derived; do not override)
// PORTS
// - clk            in   1      clock; all state updates on posedge
// - reset          in   1      synchronous, active-high
// - hit_valid      in   1      BTB hit this cycle; single-cycle event, never stalled
// - hit_index      in   IDX_W  set of hit
// - hit_way        in   $clog2(WAYS)  way that hit
// - fill_req       in   1      level request for victim; held high until fill_ack seen
// - fill_index     in   IDX_W  set needing allocation; stable while fill_req high
// - fill_ack       out  1      one-cycle pulse: fill_way valid
// - fill_way       out  $clog2(WAYS)  victim way chosen
// - lru_rindex     out  IDX_W  array read index (combinational from selected request)
// - lru_rdata      in   LRU_W  array read data (combinational)
// - lru_write      out  1      array write enable (registered)
// - lru_windex     out  IDX_W  array write index (registered)
// - lru_wdata      out  LRU_W  array write data (registered)
// - hit_count      out  16     stats, see CONFIGURATION
// - fill_count     out  16     stats
// - stall_count    out  16     stats
// BEHAVIOUR
// - Reset: P1 stage invalid, FSM=F_IDLE; fill_ack, fill_way, lru_write, lru_windex, lru_wdata, counters = 0.
// - Reset does not clear the array.
// - Select (cycle N): hit_valid wins.
//   - Else fill_req accepted when FSM=F_IDLE.
//   - lru_rindex = selected index; hit_index when idle.
// - Capture at posedge ending N into P1: op, index, way, base bits.
//   - base = P1 next bits if P1 valid and same index (forwarding), else lru_rdata.
// - Cycle N+1 (latency 1), registered outputs:
//   - lru_write=1, lru_windex=P1 index, lru_wdata=update(base, w).
//   - HIT: w = hit_way.
//   - FILL: w = victim(base); fill_ack=1, fill_way=w.
// - 4-way PLRU, bits [2:0] = {b2,b1,b0}:
//   - victim: b0=0 ? (b1?1:0) : (b2?3:2).
//   - update: w0 -> b0=1,b1=1; w1 -> b0=1,b1=0; w2 -> b0=0,b2=1; w3 -> b0=0,b2=0. Untouched bits kept.
// - 2-way: victim = b0; update b0 = ~w.
// - Fill FSM:
//   - F_IDLE -> F_UPD on fill accept.
//   - F_UPD (ack cycle) -> F_WAIT.
//   - F_WAIT -> F_IDLE when fill_req=0.
//   - Exactly one ack per request (4-phase).
// - Fill with hit_valid=1 in the same cycle: fill stalls (stays F_IDLE), no ack; stall_count++ each such cycle.
// - A hit captured while a fill is in P1 is processed the following cycle: back-to-back writes, forwarding applies.
// - Reset mid-operation: P1 discarded, no write, no ack. A fill still held high is re-accepted after reset.
// CONFIGURATION
// - Macro BTB_LRU_STATS_EN defined:
//   - hit_count: +1 per accepted hit.
//   - fill_count: +1 per fill_ack.
//   - stall_count: +1 per stalled fill cycle.
//   - All counters 16-bit, saturate at 16'hFFFF, cleared by reset.
// - Macro not defined: counters absent, ports tied to 0.
// TESTING
// - Fill idx 2, lru_rdata=3'b000 -> next cycle lru_write=1, windex=2, wdata=3'b011, fill_ack=1, fill_way=0.
// - Hit idx 5 way 3, lru_rdata=3'b111 -> next cycle windex=5, wdata=3'b010, fill_ack=0.
// - Hits idx 1 way0 then way2 back-to-back, lru_rdata stuck 3'b000 -> writes 3'b011 then forwarded 3'b110.
// - fill_req idx 4 with hit_valid high 3 cycles -> ack 1 cycle after first hit-free cycle; single ack while fill_req held; stall_count=3.
// - reset pulsed the cycle after fill accept -> no write, no ack; after release -> fill served with ack.
// - 3 hits + 1 fill: with BTB_LRU_STATS_EN -> hit_count=3, fill_count=1; without it -> both 0.

Source files
------------

// File: rtl/btb_lru_policy_ctrl_if.sv
// Fetch-stage side of the BTB pseudo-LRU policy engine: hit touch events and
// fill (victim request) handshakes.
interface btb_lru_policy_ctrl_if #(
    parameter int WAYS  = 4,
    parameter int IDX_W = 3
);
    localparam int WAY_W = $clog2(WAYS);

    // hit_valid is a one-cycle event that is always taken (no ready).
    // fill_req is a level request held with a stable fill_index until fill_ack
    // pulses for one cycle with fill_way; the requester then drops fill_req,
    // and the engine re-arms once it sees fill_req low (4-phase).
    logic             hit_valid;
    logic [IDX_W-1:0] hit_index;
    logic [WAY_W-1:0] hit_way;
    logic             fill_req;
    logic [IDX_W-1:0] fill_index;
    logic             fill_ack;
    logic [WAY_W-1:0] fill_way;

    modport master (
        output hit_valid, hit_index, hit_way, fill_req, fill_index,
        input  fill_ack, fill_way
    );

    modport slave (
        input  hit_valid, hit_index, hit_way, fill_req, fill_index,
        output fill_ack, fill_way
    );
endinterface

// File: rtl/btb_lru_policy_ctrl.sv
// Tree pseudo-LRU policy engine for the BTB: reads the LRU array, serves hit
// touches and fill victim requests, writes updated bits. Stats: BTB_LRU_STATS_EN.
module btb_lru_policy_ctrl #(
    parameter int WAYS  = 4,
    parameter int IDX_W = 3,
    parameter int LRU_W = WAYS - 1
) (
    input  logic              clk,
    input  logic              reset,
    btb_lru_policy_ctrl_if.slave bus,
    output logic [IDX_W-1:0]  lru_rindex,
    input  logic [LRU_W-1:0]  lru_rdata,
    output logic              lru_write,
    output logic [IDX_W-1:0]  lru_windex,
    output logic [LRU_W-1:0]  lru_wdata,
    output logic [15:0]       hit_count,
    output logic [15:0]       fill_count,
    output logic [15:0]       stall_count,
    output logic [1:0]        fsm_state
);
    localparam int WAY_W = $clog2(WAYS);

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_UPD  = 2'd1,
        F_WAIT = 2'd2
    } fill_state_e;

    function automatic logic [WAY_W-1:0] plru_victim(input logic [LRU_W-1:0] bits);
        logic [2:0] b;
        logic [1:0] v;
        b = 3'(bits);
        if (WAYS == 2)  v = {1'b0, b[0]};
        else if (!b[0]) v = b[1] ? 2'd1 : 2'd0;
        else            v = b[2] ? 2'd3 : 2'd2;
        return WAY_W'(v);
    endfunction

    // Bits that the touched way's path does not cross are left alone.
    function automatic logic [LRU_W-1:0] plru_update(input logic [LRU_W-1:0] bits,
                                                     input logic [WAY_W-1:0] way);
        logic [2:0] b;
        logic [1:0] w;
        b = 3'(bits);
        w = 2'(way);
        if (WAYS == 2) begin
            b[0] = ~w[0];
        end else begin
            case (w)
                2'd0: begin b[0] = 1'b1; b[1] = 1'b1; end
                2'd1: begin b[0] = 1'b1; b[1] = 1'b0; end
                2'd2: begin b[0] = 1'b0; b[2] = 1'b1; end
                2'd3: begin b[0] = 1'b0; b[2] = 1'b0; end
            endcase
        end
        return LRU_W'(b);
    endfunction

    fill_state_e      state_q, state_d;
    logic             sel_hit, sel_fill, stall;
    logic [IDX_W-1:0] sel_index;
    logic [WAY_W-1:0] sel_way;
    logic [LRU_W-1:0] base, next_bits;

    // The registered write port doubles as the P1 stage.
    logic             write_q, ack_q;
    logic [IDX_W-1:0] windex_q;
    logic [LRU_W-1:0] wdata_q;
    logic [WAY_W-1:0] way_q;

    always_comb begin
        sel_hit   = bus.hit_valid;
        sel_fill  = !bus.hit_valid && bus.fill_req && (state_q == F_IDLE);
        stall     = bus.hit_valid && bus.fill_req && (state_q == F_IDLE);
        sel_index = sel_fill ? bus.fill_index : bus.hit_index;
        // The array still holds stale bits for the set written this cycle.
        base      = (write_q && (windex_q == sel_index)) ? wdata_q : lru_rdata;
        sel_way   = sel_fill ? plru_victim(base) : bus.hit_way;
        next_bits = plru_update(base, sel_way);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            F_IDLE:  if (sel_fill) state_d = F_UPD;
            F_UPD:   state_d = F_WAIT;
            F_WAIT:  if (!bus.fill_req) state_d = F_IDLE;
            default: state_d = F_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= F_IDLE;
            write_q  <= 1'b0;
            windex_q <= '0;
            wdata_q  <= '0;
            ack_q    <= 1'b0;
            way_q    <= '0;
        end else begin
            state_q <= state_d;
            write_q <= sel_hit || sel_fill;
            ack_q   <= sel_fill;
            if (sel_hit || sel_fill) begin
                windex_q <= sel_index;
                wdata_q  <= next_bits;
            end
            if (sel_fill) way_q <= sel_way;
        end
    end

    // Reset in the P1 cycle squashes the in-flight write and ack.
    assign lru_rindex   = sel_index;
    assign lru_write    = write_q && !reset;
    assign lru_windex   = windex_q;
    assign lru_wdata    = wdata_q;
    assign bus.fill_ack = ack_q && !reset;
    assign bus.fill_way = way_q;
    assign fsm_state    = state_q;

`ifdef BTB_LRU_STATS_EN
    logic [15:0] hit_q, fill_q, stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_q   <= '0;
            fill_q  <= '0;
            stall_q <= '0;
        end else begin
            if (sel_hit && (hit_q != 16'hFFFF))  hit_q   <= hit_q + 16'd1;
            if (ack_q && (fill_q != 16'hFFFF))   fill_q  <= fill_q + 16'd1;
            if (stall && (stall_q != 16'hFFFF))  stall_q <= stall_q + 16'd1;
        end
    end

    assign hit_count   = hit_q;
    assign fill_count  = fill_q;
    assign stall_count = stall_q;
`else
    assign hit_count   = 16'd0;
    assign fill_count  = 16'd0;
    assign stall_count = 16'd0;
`endif
endmodule

// File: tb/tb_btb_lru_policy_ctrl.sv
// Bench for btb_lru_policy_ctrl: directed spec scenarios plus randomized
// hit/fill traffic against a pair-based pseudo-LRU reference model.
module tb_btb_lru_policy_ctrl;
    logic        clk;
    logic        reset;
    logic [2:0]  lru_rindex;
    logic [2:0]  lru_rdata;
    logic        lru_write;
    logic [2:0]  lru_windex;
    logic [2:0]  lru_wdata;
    logic [15:0] hit_count, fill_count, stall_count;
    logic [1:0]  fsm_state;

    int cmp_count = 0;
    int fail_count = 0;

    // LRU storage array, optionally overridden with a fixed read value.
    logic [2:0] arr [8];
    logic [2:0] pre_val [8];
    logic       preload;
    logic       force_rd;
    logic [2:0] force_val;

    // Reference model per set: which pair of ways is next victim, and which
    // way inside each pair is that pair's victim.
    logic m_pair [8];
    logic m_in0  [8];
    logic m_in1  [8];

    btb_lru_policy_ctrl_if #(.WAYS(4), .IDX_W(3)) bus ();

    btb_lru_policy_ctrl #(.WAYS(4), .IDX_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .lru_rindex (lru_rindex),
        .lru_rdata  (lru_rdata),
        .lru_write  (lru_write),
        .lru_windex (lru_windex),
        .lru_wdata  (lru_wdata),
        .hit_count  (hit_count),
        .fill_count (fill_count),
        .stall_count(stall_count),
        .fsm_state  (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign lru_rdata = force_rd ? force_val : arr[lru_rindex];

    always @(posedge clk) begin
        if (preload) begin
            for (int s = 0; s < 8; s++) arr[s] <= pre_val[s];
        end else if (lru_write) begin
            arr[lru_windex] <= lru_wdata;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        bus.hit_valid = 1'b0;
        bus.fill_req = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    function automatic logic [2:0] m_bits(input int idx);
        return {m_in1[idx], m_in0[idx], m_pair[idx]};
    endfunction

    function automatic logic [1:0] m_victim(input int idx);
        if (m_pair[idx]) return m_in1[idx] ? 2'd3 : 2'd2;
        return m_in0[idx] ? 2'd1 : 2'd0;
    endfunction

    task automatic m_touch(input int idx, input int way);
        m_pair[idx] = (way < 2);
        if (way < 2) m_in0[idx] = (way == 0);
        else         m_in1[idx] = (way == 2);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.hit_valid = 1'b0;
        bus.fill_req = 1'b0;
        bus.hit_index = '0;
        bus.hit_way = '0;
        bus.fill_index = '0;
        preload = 1'b0;
        force_rd = 1'b1;
        force_val = 3'b000;
        step();
        step();
        reset = 1'b0;
        #1;
        cmp_count++; if (lru_write !== 1'b0) begin fail_count++; $display("FAIL reset_write got %0b want 0", lru_write); end
        cmp_count++; if (lru_windex !== 3'd0) begin fail_count++; $display("FAIL reset_windex got %0d want 0", lru_windex); end
        cmp_count++; if (lru_wdata !== 3'd0) begin fail_count++; $display("FAIL reset_wdata got %b want 000", lru_wdata); end
        cmp_count++; if (bus.fill_ack !== 1'b0) begin fail_count++; $display("FAIL reset_ack got %0b want 0", bus.fill_ack); end
        cmp_count++; if (bus.fill_way !== 2'd0) begin fail_count++; $display("FAIL reset_way got %0d want 0", bus.fill_way); end
        cmp_count++; if (fsm_state !== 2'd0) begin fail_count++; $display("FAIL reset_state got %0d want 0", fsm_state); end
        cmp_count++; if ({hit_count, fill_count, stall_count} !== 48'd0) begin fail_count++; $display("FAIL reset_counts got %0d/%0d/%0d want 0/0/0", hit_count, fill_count, stall_count); end
    endtask

    task automatic test_fill_basic();
        force_val = 3'b000;
        bus.fill_index = 3'd2;
        bus.fill_req = 1'b1;
        step();
        cmp_count++; if (lru_write !== 1'b1) begin fail_count++; $display("FAIL fill_write got %0b want 1", lru_write); end
        cmp_count++; if (lru_windex !== 3'd2) begin fail_count++; $display("FAIL fill_windex got %0d want 2", lru_windex); end
        cmp_count++; if (lru_wdata !== 3'b011) begin fail_count++; $display("FAIL fill_wdata got %b want 011", lru_wdata); end
        cmp_count++; if (bus.fill_ack !== 1'b1) begin fail_count++; $display("FAIL fill_ack got %0b want 1", bus.fill_ack); end
        cmp_count++; if (bus.fill_way !== 2'd0) begin fail_count++; $display("FAIL fill_way got %0d want 0", bus.fill_way); end
        bus.fill_req = 1'b0;
        step();
        cmp_count++; if (bus.fill_ack !== 1'b0) begin fail_count++; $display("FAIL fill_ack_pulse got %0b want 0", bus.fill_ack); end
        cmp_count++; if (lru_write !== 1'b0) begin fail_count++; $display("FAIL fill_write_pulse got %0b want 0", lru_write); end
        step();
    endtask

    task automatic test_hit_basic();
        force_val = 3'b111;
        bus.hit_valid = 1'b1;
        bus.hit_index = 3'd5;
        bus.hit_way = 2'd3;
        step();
        bus.hit_valid = 1'b0;
        cmp_count++; if (lru_write !== 1'b1) begin fail_count++; $display("FAIL hit_write got %0b want 1", lru_write); end
        cmp_count++; if (lru_windex !== 3'd5) begin fail_count++; $display("FAIL hit_windex got %0d want 5", lru_windex); end
        cmp_count++; if (lru_wdata !== 3'b010) begin fail_count++; $display("FAIL hit_wdata got %b want 010", lru_wdata); end
        cmp_count++; if (bus.fill_ack !== 1'b0) begin fail_count++; $display("FAIL hit_ack got %0b want 0", bus.fill_ack); end
        step();
    endtask

    task automatic test_back_to_back();
        force_val = 3'b000;
        bus.hit_valid = 1'b1;
        bus.hit_index = 3'd1;
        bus.hit_way = 2'd0;
        step();
        cmp_count++; if ({lru_write, lru_windex, lru_wdata} !== {1'b1, 3'd1, 3'b011}) begin fail_count++; $display("FAIL b2b_first got w=%0b i=%0d d=%b want w=1 i=1 d=011", lru_write, lru_windex, lru_wdata); end
        bus.hit_way = 2'd2;
        step();
        bus.hit_valid = 1'b0;
        cmp_count++; if ({lru_write, lru_windex, lru_wdata} !== {1'b1, 3'd1, 3'b110}) begin fail_count++; $display("FAIL b2b_forward got w=%0b i=%0d d=%b want w=1 i=1 d=110", lru_write, lru_windex, lru_wdata); end
        step();
    endtask

    task automatic test_stall();
        int acks;
        apply_reset();
        force_val = 3'b000;
        bus.fill_index = 3'd4;
        bus.fill_req = 1'b1;
        bus.hit_valid = 1'b1;
        bus.hit_index = 3'd0;
        bus.hit_way = 2'd1;
        for (int i = 0; i < 3; i++) begin
            step();
            cmp_count++; if (bus.fill_ack !== 1'b0) begin fail_count++; $display("FAIL stall_ack_early cycle %0d got %0b want 0", i, bus.fill_ack); end
        end
        bus.hit_valid = 1'b0;
        step();
        cmp_count++; if ({bus.fill_ack, bus.fill_way, lru_windex} !== {1'b1, 2'd0, 3'd4}) begin fail_count++; $display("FAIL stall_ack got ack=%0b way=%0d idx=%0d want ack=1 way=0 idx=4", bus.fill_ack, bus.fill_way, lru_windex); end
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.fill_ack === 1'b1) acks++;
        end
        cmp_count++; if (acks !== 0) begin fail_count++; $display("FAIL stall_single_ack got %0d extra acks want 0", acks); end
        bus.fill_req = 1'b0;
        step();
        step();
`ifdef BTB_LRU_STATS_EN
        cmp_count++; if (stall_count !== 16'd3) begin fail_count++; $display("FAIL stall_count got %0d want 3", stall_count); end
`else
        cmp_count++; if (stall_count !== 16'd0) begin fail_count++; $display("FAIL stall_count got %0d want 0", stall_count); end
`endif
    endtask

    task automatic test_reset_mid();
        force_val = 3'b000;
        bus.fill_index = 3'd6;
        bus.fill_req = 1'b1;
        step();
        reset = 1'b1;
        #1;
        cmp_count++; if ({lru_write, bus.fill_ack} !== 2'b00) begin fail_count++; $display("FAIL rstmid_squash got w=%0b ack=%0b want 0 0", lru_write, bus.fill_ack); end
        step();
        reset = 1'b0;
        #1;
        cmp_count++; if ({lru_write, bus.fill_ack} !== 2'b00) begin fail_count++; $display("FAIL rstmid_after got w=%0b ack=%0b want 0 0", lru_write, bus.fill_ack); end
        step();
        cmp_count++; if ({bus.fill_ack, bus.fill_way, lru_write, lru_windex, lru_wdata} !== {1'b1, 2'd0, 1'b1, 3'd6, 3'b011}) begin fail_count++; $display("FAIL rstmid_reaccept got ack=%0b way=%0d w=%0b i=%0d d=%b want 1 0 1 6 011", bus.fill_ack, bus.fill_way, lru_write, lru_windex, lru_wdata); end
        bus.fill_req = 1'b0;
        step();
        step();
    endtask

    task automatic test_stats();
        apply_reset();
        force_val = 3'b000;
        for (int i = 0; i < 3; i++) begin
            bus.hit_valid = 1'b1;
            bus.hit_index = 3'(i);
            bus.hit_way = 2'(i);
            step();
        end
        bus.hit_valid = 1'b0;
        bus.fill_index = 3'd3;
        bus.fill_req = 1'b1;
        step();
        bus.fill_req = 1'b0;
        step();
        step();
`ifdef BTB_LRU_STATS_EN
        cmp_count++; if ({hit_count, fill_count} !== {16'd3, 16'd1}) begin fail_count++; $display("FAIL stats got hit=%0d fill=%0d want 3 1", hit_count, fill_count); end
`else
        cmp_count++; if ({hit_count, fill_count} !== 32'd0) begin fail_count++; $display("FAIL stats got hit=%0d fill=%0d want 0 0", hit_count, fill_count); end
`endif
    endtask

    task automatic test_random();
        logic       exp_write, exp_ack, outstanding;
        logic [2:0] exp_idx, exp_bits;
        logic [1:0] exp_way;
        int         cool, n_hit, n_fill, n_stall, idx, way, errs;
        localparam int N = 400;
        force_rd = 1'b0;
        reset = 1'b1;
        bus.hit_valid = 1'b0;
        bus.fill_req = 1'b0;
        for (int s = 0; s < 8; s++) begin
            pre_val[s] = 3'($urandom_range(0, 7));
            m_pair[s] = pre_val[s][0];
            m_in0[s]  = pre_val[s][1];
            m_in1[s]  = pre_val[s][2];
        end
        preload = 1'b1;
        step();
        preload = 1'b0;
        step();
        reset = 1'b0;
        outstanding = 1'b0;
        cool = 0; n_hit = 0; n_fill = 0; n_stall = 0; errs = 0;
        for (int c = 0; c < N; c++) begin
            if (!bus.fill_req && cool == 0 && c < N - 8 && $urandom_range(0, 2) == 0) begin
                bus.fill_req = 1'b1;
                bus.fill_index = 3'($urandom_range(0, 3));
            end
            bus.hit_valid = (c < N - 8) && ($urandom_range(0, 9) < 4);
            bus.hit_index = 3'($urandom_range(0, 3));
            bus.hit_way = 2'($urandom_range(0, 3));
            exp_write = 1'b0;
            exp_ack = 1'b0;
            exp_idx = '0;
            exp_bits = '0;
            exp_way = '0;
            if (bus.hit_valid) begin
                idx = int'(bus.hit_index);
                way = int'(bus.hit_way);
                m_touch(idx, way);
                exp_write = 1'b1;
                exp_idx = 3'(idx);
                exp_bits = m_bits(idx);
                n_hit++;
                if (bus.fill_req && !outstanding) n_stall++;
            end else if (bus.fill_req && !outstanding) begin
                idx = int'(bus.fill_index);
                exp_way = m_victim(idx);
                m_touch(idx, int'(exp_way));
                exp_write = 1'b1;
                exp_ack = 1'b1;
                exp_idx = 3'(idx);
                exp_bits = m_bits(idx);
                outstanding = 1'b1;
                n_fill++;
            end
            step();
            cmp_count++;
            if ((lru_write !== exp_write) || (bus.fill_ack !== exp_ack) ||
                (exp_write && ((lru_windex !== exp_idx) || (lru_wdata !== exp_bits))) ||
                (exp_ack && (bus.fill_way !== exp_way))) begin
                fail_count++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random cycle %0d got w=%0b i=%0d d=%b ack=%0b way=%0d want w=%0b i=%0d d=%b ack=%0b way=%0d",
                             c, lru_write, lru_windex, lru_wdata, bus.fill_ack, bus.fill_way,
                             exp_write, exp_idx, exp_bits, exp_ack, exp_way);
            end
            if (cool > 0) cool--;
            if (bus.fill_ack === 1'b1) begin
                bus.fill_req = 1'b0;
                outstanding = 1'b0;
                cool = 2 + $urandom_range(0, 2);
            end
        end
        bus.fill_req = 1'b0;
        bus.hit_valid = 1'b0;
        step();
        step();
`ifdef BTB_LRU_STATS_EN
        cmp_count++; if ({hit_count, fill_count, stall_count} !== {16'(n_hit), 16'(n_fill), 16'(n_stall)}) begin fail_count++; $display("FAIL random_stats got %0d/%0d/%0d want %0d/%0d/%0d", hit_count, fill_count, stall_count, n_hit, n_fill, n_stall); end
`else
        cmp_count++; if ({hit_count, fill_count, stall_count} !== 48'd0) begin fail_count++; $display("FAIL random_stats got %0d/%0d/%0d want 0/0/0", hit_count, fill_count, stall_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_fill_basic();
        test_hit_basic();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_stats();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end
endmodule
